pfd_feedback_divider: RTL
=========================

# pfd_feedback_divider

Programmable integer-N feedback divider that produces the `sig` input of the phase-frequency detector from the oscillator clock. It divides `clk` by a runtime-selectable ratio N and produces a glitch-free, registered output with near-50 % duty. Ratio updates arrive over a valid/ready handshake and take effect only at a period boundary, so the detector never sees a truncated or stretched edge.

## Interface
- `WIDTH`, 8: width of the ratio and the internal counter.
- `RESET_RATIO`, 4: active ratio after reset. Must be in the range 2..2^WIDTH-1.

- `clk` input 1: oscillator clock, the only clock.
- `rstn` input 1: asynchronous, active-low reset.
- `en` input 1: run enable, synchronous.
- `ratio` input WIDTH: requested divide ratio N.
- `ratio_valid` input 1: `ratio` is valid this cycle.
- `ratio_ready` output 1: the shadow register is empty and can accept a ratio.
- `ratio_applied` output 1: one-cycle pulse when the shadow ratio becomes active.
- `sig` output 1: divided clock, driven from a flop. Feeds the detector's `sig` input.
- `wrap` output 1: high during the last cycle of each output period.

## Operation
- **State.** The block holds:
  - `cnt` (WIDTH bits),
  - `active` ratio `N` (WIDTH bits),
  - `shadow` ratio plus a `pending` flag,
  - a `running` flag,
  - the `sig` flop.
- **Duty.** Let H = ceil(N/2). `sig` is high while `cnt` < H and low for the remaining N−H cycles.
- **Idle (`running` = 0).**
  - Entered by reset, or by `en` = 0 sampled at any edge.
  - Values: `cnt` = 0, `sig` = 0.
  - Turning the block off mid-period abandons that period immediately.
- **Start.** At an edge where `en` = 1 and `running` = 0:
  - `running` ← 1, `cnt` ← 0, `sig` ← 1.
  - If `pending` = 1, the shadow ratio is applied at this same edge.
- **Run.** At each edge where `en` = 1 and `running` = 1:
  - If `cnt` = N−1, then `cnt` ← 0. Otherwise `cnt` ← `cnt`+1.
  - `sig` ← (next `cnt` < H). `sig` and `cnt` are always consistent in the same cycle.
- **Wrap.** `wrap` = `running` & (`cnt` = N−1). This output is combinational from flops.
- **Handshake.**
  - `ratio_ready` = !`pending`.
  - A transfer occurs when `ratio_valid` & `ratio_ready` at an edge. At that edge `shadow` ← `ratio` and `pending` ← 1.
  - While `pending` = 1, `ratio_valid` is ignored and the value is not captured.
- **Apply.** When `pending` = 1 and either the run is at the wrap edge (`wrap` = 1 with `en` = 1) or the block is idle:
  - `active` ← clamp(`shadow`), where clamp maps 0 and 1 to 2.
  - `pending` ← 0.
  - `ratio_applied` = 1 for the following cycle.
  - The new N governs the period that starts at that edge.
- **Acceptance on a wrap edge.** A ratio accepted on a wrap edge cannot have been pending, so it is not applied at that wrap. It is applied at the next wrap.
- **Width rules.**
  - Compare `cnt` with N−1, with N ≥ 2 guaranteed by the clamp.
  - Compute H as (N+1)>>1 in WIDTH+1 bits to avoid overflow at N = 2^WIDTH−1.
  - `cnt` never exceeds N−1.

## Timing
- **Reset (asynchronous assert).** Values: `cnt` = 0, `sig` = 0, `running` = 0, `active` = `RESET_RATIO`, `pending` = 0, `ratio_applied` = 0. Consequently `ratio_ready` = 1 and `wrap` = 0.
- **Deassertion.** `rstn` is deasserted synchronously to `clk` by the enclosing design.
- **First output edge.** `sig` rises 1 edge after `en` is first sampled high. Subsequent rising edges of `sig` are exactly N `clk` cycles apart.
- **Apply latency.** Latency from acceptance to effect is at most N_old + 1 edges while running, and 1 edge while idle.
- **Reset mid-period.** Any pending ratio is discarded and `active` returns to `RESET_RATIO`.
- **`en` deassertion.** `sig` falls 1 edge after `en` is sampled low, if it was high.

## Test plan
- **Reset and start.** Reset, `RESET_RATIO` = 4, `en` = 1 → `sig` pattern 1,1,0,0 repeating. `wrap` is high on every 4th cycle. After reset: `ratio_ready` = 1, `sig` = 0.
- **Odd ratio.** Write N = 5 while idle and hold `en` = 0 → `ratio_applied` pulses 1 cycle later. Set `en` = 1 → `sig` is high 3 cycles and low 2 cycles, repeating.
- **Mid-period update.** Running at N = 4, write N = 6 at `cnt` = 1:
  - `ratio_ready` drops.
  - The current period completes with 4 cycles.
  - `ratio_applied` pulses after the wrap.
  - The next period is 6 cycles long (3 high, 3 low).
  - `ratio_ready` then returns to 1.
- **Write on a wrap edge.** Write N = 3 exactly on a wrap edge → the following period still uses the old N. N = 3 takes effect one period later.
- **Clamp and back-pressure.**
  - Write N = 1 → period 2, `sig` 1,0 alternating.
  - While `pending` = 1, assert `ratio_valid` with N = 9 → the value is ignored; the next applied ratio is the first accepted value.
- **Asynchronous reset and `en` drop mid-period.**
  - Assert `rstn` = 0 at `cnt` = 2 with `pending` = 1 → all outputs reach their reset values immediately and the pending ratio is lost.
  - Separately, drop `en` at `cnt` = 1 → `sig` = 0 on the next edge. Re-enabling restarts from `cnt` = 0.

Source files
------------

// File: rtl/pfd_feedback_divider.sv
// Purpose: programmable integer-N clock divider feeding the PFD sig input, ratio updates via shadow register.
// Latency: sig rises 1 edge after en is sampled high; a new ratio takes effect at the next period boundary (<= N_old+1 edges).
// Backpressure: ratio_ready drops while a shadow ratio is pending; ratio_valid is ignored until it is applied.
module pfd_feedback_divider #(
  parameter int WIDTH       = 8,
  parameter int RESET_RATIO = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] ratio,
  input  logic             ratio_valid,
  output logic             ratio_ready,
  output logic             ratio_applied,
  output logic             sig,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] shadow_q;
  logic             pending_q;
  logic             running_q;

  logic [WIDTH-1:0] n_last;
  logic [WIDTH-1:0] shadow_clamped;
  logic [WIDTH-1:0] n_next;
  logic [WIDTH:0]   half;
  logic [WIDTH-1:0] cnt_nxt;
  logic             sig_nxt;
  logic             accept;
  logic             apply;

  // Active ratio is never below 2, so N-1 cannot underflow.
  assign n_last      = active_q - WIDTH'(1);
  assign wrap        = running_q && (cnt_q == n_last);
  assign ratio_ready = !pending_q;
  assign accept      = ratio_valid && !pending_q;
  // A pending ratio is promoted at a running period boundary or at any idle edge.
  assign apply       = pending_q && ((wrap && en) || !running_q);

  // Next-period ratio, high-phase length and next count/sig values.
  always_comb begin
    shadow_clamped = shadow_q;
    if (shadow_q < WIDTH'(2)) begin
      shadow_clamped = WIDTH'(2);
    end
    n_next = apply ? shadow_clamped : active_q;
    // One extra bit keeps N+1 from overflowing when N is the largest ratio.
    half = ({1'b0, n_next} + (WIDTH+1)'(1)) >> 1;
    cnt_nxt = cnt_q + WIDTH'(1);
    if (!en || !running_q || wrap) begin
      cnt_nxt = '0;
    end
    sig_nxt = en && ({1'b0, cnt_nxt} < half);
  end

  // Counter, run flag and registered divided output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
      sig       <= 1'b0;
    end else begin
      cnt_q     <= cnt_nxt;
      running_q <= en;
      sig       <= sig_nxt;
    end
  end

  // Shadow/active ratio handoff; accept and apply are mutually exclusive on pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q      <= WIDTH'(RESET_RATIO);
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      ratio_applied <= 1'b0;
    end else begin
      ratio_applied <= apply;
      if (apply) begin
        active_q <= shadow_clamped;
      end
      if (accept) begin
        shadow_q  <= ratio;
        pending_q <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule
